// File: rtl/multicycle_control_unit.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback and
// drives every datapath enable and mux select from the current state and IR fields.
module multicycle_control_unit #(
    parameter bit BRANCH_FULL = 1'b1,
    parameter bit MEM_WAIT_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       EQ,
    input  logic       LT,
    input  logic       LTU,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       AdrSrc,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [3:0] ALUctrl,
    output logic [2:0] ImmSrc,
    output logic [3:0] state,
    output logic       illegal
);

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAdr   = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StExecR    = 4'd6,
        StExecI    = 4'd7,
        StAluWb    = 4'd8,
        StJal      = 4'd9,
        StBranch   = 4'd10,
        StLui      = 4'd11,
        StHalt     = 4'd15
    } state_e;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpRType  = 7'b0110011;
    localparam logic [6:0] OpIType  = 7'b0010011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLui    = 7'b0110111;

    localparam logic [3:0] AluAdd  = 4'd0;
    localparam logic [3:0] AluSub  = 4'd1;
    localparam logic [3:0] AluAnd  = 4'd2;
    localparam logic [3:0] AluOr   = 4'd3;
    localparam logic [3:0] AluXor  = 4'd4;
    localparam logic [3:0] AluSlt  = 4'd5;
    localparam logic [3:0] AluSltu = 4'd6;
    localparam logic [3:0] AluSll  = 4'd7;
    localparam logic [3:0] AluSrl  = 4'd8;
    localparam logic [3:0] AluSra  = 4'd9;

    state_e state_q, state_d;
    logic   rdy;
    logic   branch_ok;
    logic   taken;
    logic   [3:0] alu_op;

    assign rdy   = MEM_WAIT_EN ? mem_ready : 1'b1;
    assign state = state_q;

    // funct3 010/011 never encode a branch; 1xx only exist with the full branch set.
    assign branch_ok = (funct3[2:1] == 2'b00) || (BRANCH_FULL && funct3[2]);

    always_comb begin
        taken = 1'b0;
        unique case (funct3)
            3'b000:  taken = EQ;
            3'b001:  taken = !EQ;
            3'b100:  taken = LT;
            3'b101:  taken = !LT;
            3'b110:  taken = LTU;
            3'b111:  taken = !LTU;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        alu_op = AluAdd;
        unique case (funct3)
            3'b000:  alu_op = (state_q == StExecR && funct7_5) ? AluSub : AluAdd;
            3'b001:  alu_op = AluSll;
            3'b010:  alu_op = AluSlt;
            3'b011:  alu_op = AluSltu;
            3'b100:  alu_op = AluXor;
            3'b101:  alu_op = funct7_5 ? AluSra : AluSrl;
            3'b110:  alu_op = AluOr;
            default: alu_op = AluAnd;
        endcase
    end

    always_comb begin
        ImmSrc = 3'b000;
        unique case (op)
            OpStore:  ImmSrc = 3'b001;
            OpBranch: ImmSrc = 3'b010;
            OpJal:    ImmSrc = 3'b011;
            OpLui:    ImmSrc = 3'b100;
            default:  ImmSrc = 3'b000;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFetch:    if (rdy) state_d = StDecode;
            StDecode: begin
                unique case (op)
                    OpLoad, OpStore: state_d = StMemAdr;
                    OpRType:         state_d = StExecR;
                    OpIType:         state_d = StExecI;
                    OpJal:           state_d = StJal;
                    OpBranch:        state_d = branch_ok ? StBranch : StHalt;
                    OpLui:           state_d = StLui;
                    default:         state_d = StHalt;
                endcase
            end
            StMemAdr:   state_d = op[5] ? StMemWrite : StMemRead;
            StMemRead:  if (rdy) state_d = StMemWb;
            StMemWb:    state_d = StFetch;
            StMemWrite: if (rdy) state_d = StFetch;
            StExecR,
            StExecI,
            StJal,
            StLui:      state_d = StAluWb;
            StAluWb:    state_d = StFetch;
            StBranch:   state_d = StFetch;
            StHalt:     state_d = StHalt;
            default:    state_d = StHalt;
        endcase
    end

    always_comb begin
        PCWrite   = 1'b0;
        IRWrite   = 1'b0;
        RegWrite  = 1'b0;
        MemWrite  = 1'b0;
        AdrSrc    = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ALUctrl   = AluAdd;
        illegal   = 1'b0;
        unique case (state_q)
            StFetch: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = rdy;
                PCWrite   = rdy;
            end
            StDecode: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            StMemAdr: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            StMemRead:  AdrSrc = 1'b1;
            StMemWb: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
            end
            StMemWrite: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            StExecR, StExecI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = (state_q == StExecR) ? 2'b00 : 2'b01;
                ALUctrl = alu_op;
            end
            StAluWb:    RegWrite = 1'b1;
            StJal: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                PCWrite = 1'b1;
            end
            StBranch: begin
                ALUSrcA = 2'b10;
                ALUctrl = AluSub;
                PCWrite = taken;
            end
            StLui: begin
                ALUSrcA = 2'b11;
                ALUSrcB = 2'b01;
            end
            default:    illegal = 1'b1;
        endcase
        // Reset must mask the Mealy enables immediately, not just after the state flop clears.
        if (!rst_n) begin
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            RegWrite = 1'b0;
            MemWrite = 1'b0;
            illegal  = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench: instruction-level model expands each instruction into per-cycle expected
// outputs; a negedge monitor pops and compares against the DUT.
module tb_multicycle_control_unit;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw, irw, rw, mw, adr;
        logic [1:0] rs, sa, sb;
        logic [3:0] alu;
        logic [2:0] imm;
        logic       ill;
    } out_t;

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic       f75, eq, lt, ltu, rdy, rstn;
        out_t       exp;
        string      tag;
    } cyc_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rst_n2 = 1'b0;
    logic [6:0] op = '0;
    logic [2:0] funct3 = '0;
    logic funct7_5 = 1'b0, EQ = 1'b0, LT = 1'b0, LTU = 1'b0, mem_ready = 1'b0;

    logic PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
    logic [3:0] ALUctrl, state;
    logic [2:0] ImmSrc;
    logic PCWrite2, IRWrite2, RegWrite2, MemWrite2, AdrSrc2, illegal2;
    logic [1:0] ResultSrc2, ALUSrcA2, ALUSrcB2;
    logic [3:0] ALUctrl2, state2;
    logic [2:0] ImmSrc2;

    int checks = 0;
    int errors = 0;
    cyc_t plan[$];
    out_t sb_q[$];
    string tag_q[$];
    logic [6:0] c_op;
    logic [2:0] c_f3;
    logic c_f75, c_eq, c_lt, c_ltu;

    always #5 clk = ~clk;

    multicycle_control_unit dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7_5(funct7_5),
        .EQ(EQ), .LT(LT), .LTU(LTU), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
        .AdrSrc(AdrSrc), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUctrl(ALUctrl), .ImmSrc(ImmSrc), .state(state), .illegal(illegal)
    );

    multicycle_control_unit #(.BRANCH_FULL(1'b0), .MEM_WAIT_EN(1'b0)) dut_nb (
        .clk(clk), .rst_n(rst_n2), .op(op), .funct3(funct3), .funct7_5(funct7_5),
        .EQ(EQ), .LT(LT), .LTU(LTU), .mem_ready(mem_ready),
        .PCWrite(PCWrite2), .IRWrite(IRWrite2), .RegWrite(RegWrite2), .MemWrite(MemWrite2),
        .AdrSrc(AdrSrc2), .ResultSrc(ResultSrc2), .ALUSrcA(ALUSrcA2), .ALUSrcB(ALUSrcB2),
        .ALUctrl(ALUctrl2), .ImmSrc(ImmSrc2), .state(state2), .illegal(illegal2)
    );

    function automatic logic [2:0] imm_of(input logic [6:0] o);
        case (o)
            7'b0100011: return 3'b001;
            7'b1100011: return 3'b010;
            7'b1101111: return 3'b011;
            7'b0110111: return 3'b100;
            default:    return 3'b000;
        endcase
    endfunction

    function automatic logic [3:0] alu_of(input logic is_r, input logic [2:0] f3, input logic f75);
        case (f3)
            3'd0:    return (is_r && f75) ? 4'd1 : 4'd0;
            3'd1:    return 4'd7;
            3'd2:    return 4'd5;
            3'd3:    return 4'd6;
            3'd4:    return 4'd4;
            3'd5:    return f75 ? 4'd9 : 4'd8;
            3'd6:    return 4'd3;
            default: return 4'd2;
        endcase
    endfunction

    function automatic logic taken_of(input logic [2:0] f3, input logic eq, input logic lt,
                                      input logic ltu);
        case (f3)
            3'd0:    return eq;
            3'd1:    return !eq;
            3'd4:    return lt;
            3'd5:    return !lt;
            3'd6:    return ltu;
            default: return !ltu;
        endcase
    endfunction

    function automatic out_t mk(input logic [3:0] st, input logic [2:0] imm);
        out_t e = '0;
        e.st  = st;
        e.imm = imm;
        return e;
    endfunction

    function automatic out_t fetch_rec(input logic [2:0] imm, input logic go);
        out_t e = mk(4'd0, imm);
        e.sb  = 2'b10;
        e.rs  = 2'b10;
        e.pcw = go;
        e.irw = go;
        return e;
    endfunction

    task automatic add(input logic rdy, input logic rstn, input out_t e, input string tag);
        cyc_t c;
        c.op = c_op; c.f3 = c_f3; c.f75 = c_f75;
        c.eq = c_eq; c.lt = c_lt; c.ltu = c_ltu;
        c.rdy = rdy; c.rstn = rstn; c.exp = e; c.tag = tag;
        plan.push_back(c);
    endtask

    task automatic add_reset();
        add(1'($urandom), 1'b0, fetch_rec(imm_of(c_op), 1'b0), "reset");
    endtask

    task automatic add_aluwb();
        out_t e = mk(4'd8, imm_of(c_op));
        e.rw = 1'b1;
        add(1'($urandom), 1'b1, e, "aluwb");
    endtask

    // Expands one instruction into its cycle-by-cycle expected behaviour.
    task automatic build(input logic [6:0] o, input logic [2:0] f3, input logic f75,
                         input logic eq, input logic lt, input logic ltu,
                         input int wf, input int wm);
        out_t e;
        logic [2:0] imm;
        c_op = o; c_f3 = f3; c_f75 = f75; c_eq = eq; c_lt = lt; c_ltu = ltu;
        imm = imm_of(o);
        for (int i = 0; i <= wf; i++) add(i == wf, 1'b1, fetch_rec(imm, i == wf), "fetch");
        e = mk(4'd1, imm); e.sa = 2'b01; e.sb = 2'b01;
        add(1'($urandom), 1'b1, e, "decode");
        if (o == 7'b0000011 || o == 7'b0100011) begin
            e = mk(4'd2, imm); e.sa = 2'b10; e.sb = 2'b01;
            add(1'($urandom), 1'b1, e, "memadr");
            for (int i = 0; i <= wm; i++) begin
                e = mk(o[5] ? 4'd5 : 4'd3, imm);
                e.adr = 1'b1;
                e.mw = o[5];
                add(i == wm, 1'b1, e, o[5] ? "memwrite" : "memread");
            end
            if (!o[5]) begin
                e = mk(4'd4, imm); e.rs = 2'b01; e.rw = 1'b1;
                add(1'($urandom), 1'b1, e, "memwb");
            end
        end else if (o == 7'b0110011 || o == 7'b0010011) begin
            e = mk(o[5] ? 4'd6 : 4'd7, imm);
            e.sa = 2'b10; e.sb = o[5] ? 2'b00 : 2'b01;
            e.alu = alu_of(o[5], f3, f75);
            add(1'($urandom), 1'b1, e, "exec");
            add_aluwb();
        end else if (o == 7'b1101111) begin
            e = mk(4'd9, imm); e.sa = 2'b01; e.sb = 2'b10; e.pcw = 1'b1;
            add(1'($urandom), 1'b1, e, "jal");
            add_aluwb();
        end else if (o == 7'b0110111) begin
            e = mk(4'd11, imm); e.sa = 2'b11; e.sb = 2'b01;
            add(1'($urandom), 1'b1, e, "lui");
            add_aluwb();
        end else if (o == 7'b1100011 && f3 != 3'b010 && f3 != 3'b011) begin
            e = mk(4'd10, imm); e.sa = 2'b10; e.alu = 4'd1; e.pcw = taken_of(f3, eq, lt, ltu);
            add(1'($urandom), 1'b1, e, "branch");
        end else begin
            e = mk(4'd15, imm); e.ill = 1'b1;
            for (int i = 0; i < 3; i++) add(1'($urandom), 1'b1, e, "halt");
            add_reset();
        end
    endtask

    function automatic out_t grab1();
        return {state, PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ResultSrc, ALUSrcA,
                ALUSrcB, ALUctrl, ImmSrc, illegal};
    endfunction

    function automatic out_t grab2();
        return {state2, PCWrite2, IRWrite2, RegWrite2, MemWrite2, AdrSrc2, ResultSrc2,
                ALUSrcA2, ALUSrcB2, ALUctrl2, ImmSrc2, illegal2};
    endfunction

    task automatic compare(input out_t got, input out_t exp, input string tag);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got st=%0d vec=%h, required st=%0d vec=%h",
                     tag, $time, got.st, got, exp.st, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) compare(grab1(), sb_q.pop_front(), tag_q.pop_front());
    end

    initial begin
        logic [6:0] ops[7];
        logic [6:0] o;
        cyc_t c;
        out_t e;
        ops[0] = 7'b0000011; ops[1] = 7'b0100011; ops[2] = 7'b0110011; ops[3] = 7'b0010011;
        ops[4] = 7'b1101111; ops[5] = 7'b1100011; ops[6] = 7'b0110111;

        c_op = 7'b0110011; c_f3 = '0; c_f75 = 0; c_eq = 0; c_lt = 0; c_ltu = 0;
        repeat (3) add_reset();
        build(7'b0110011, 3'b000, 1'b0, 0, 0, 0, 0, 0);        // ADD
        build(7'b0000011, 3'b010, 1'b0, 0, 0, 0, 0, 2);        // LW, 2 wait cycles
        build(7'b1100011, 3'b110, 1'b0, 0, 0, 1, 0, 0);        // BLTU taken
        build(7'b1100011, 3'b110, 1'b0, 1, 1, 0, 0, 0);        // BLTU not taken
        build(7'b0010011, 3'b101, 1'b1, 0, 0, 0, 1, 0);        // SRAI
        build(7'b0010011, 3'b000, 1'b1, 0, 0, 0, 0, 0);        // ADDI with IR[30]=1
        build(7'b1101111, 3'b000, 1'b0, 0, 0, 0, 2, 0);        // JAL
        build(7'b0100011, 3'b010, 1'b0, 0, 0, 0, 0, 2);        // SW, then reset mid-wait
        void'(plan.pop_back());
        void'(plan.pop_back());
        add_reset();
        build(7'b0000000, 3'b000, 1'b0, 0, 0, 0, 0, 0);        // illegal opcode
        for (int n = 0; n < 200; n++) begin
            o = ($urandom_range(0, 7) == 7) ? 7'($urandom) : ops[$urandom_range(0, 6)];
            build(o, 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                  $urandom_range(0, 2), $urandom_range(0, 2));
        end

        while (plan.size() > 0) begin
            c = plan.pop_front();
            @(posedge clk);
            #1;
            op = c.op; funct3 = c.f3; funct7_5 = c.f75;
            EQ = c.eq; LT = c.lt; LTU = c.ltu;
            mem_ready = c.rdy; rst_n = c.rstn;
            sb_q.push_back(c.exp);
            tag_q.push_back(c.tag);
        end
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        @(posedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending entries, required 0", sb_q.size());
        end

        // Reduced-branch, no-wait variant: BLTU is illegal and mem_ready is ignored.
        op = 7'b1100011; funct3 = 3'b110; funct7_5 = 0; LTU = 1'b1; mem_ready = 1'b0;
        @(negedge clk);
        compare(grab2(), fetch_rec(3'b010, 1'b0), "nb_reset");
        @(posedge clk);
        #1 rst_n2 = 1'b1;
        @(negedge clk);
        compare(grab2(), fetch_rec(3'b010, 1'b1), "nb_fetch_nowait");
        e = mk(4'd1, 3'b010); e.sa = 2'b01; e.sb = 2'b01;
        @(negedge clk);
        compare(grab2(), e, "nb_decode");
        e = mk(4'd15, 3'b010); e.ill = 1'b1;
        repeat (3) begin
            @(negedge clk);
            compare(grab2(), e, "nb_halt");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Finite-state control unit for the multicycle RV32I core. It replaces the single-cycle combinational decoder with a registered state machine that sequences fetch, decode, execute, memory and writeback over several cycles and drives every datapath enable. Over the single-cycle version it adds the full branch set (BLT/BGE/BLTU/BGEU), JAL, LUI, shifts/XOR/SLTU, a memory wait-state handshake and an illegal-instruction halt. It sits between the instruction register and the shared-memory multicycle datapath.

## Interface
- BRANCH_FULL, 1, 1 = decode funct3 100–111 branches; 0 = those encodings are illegal
- MEM_WAIT_EN, 1, 1 = honour mem_ready; 0 = mem_ready treated as constant 1
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- op  in  7  IR[6:0]; funct3 in 3 IR[14:12]; funct7_5 in 1 IR[30]
- EQ, LT, LTU  in  1 each  ALU compare flags (rs1==rs2, signed <, unsigned <)
- mem_ready  in  1  memory completes the current access this cycle
- PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc  out  1 each  datapath enables/select
- ResultSrc  out  2  00 ALUOut, 01 read data, 10 ALU result
- ALUSrcA  out  2  00 PC, 01 OldPC, 10 rs1, 11 zero; ALUSrcB out 2: 00 rs2, 01 imm, 10 const 4
- ALUctrl  out  4  0 ADD,1 SUB,2 AND,3 OR,4 XOR,5 SLT,6 SLTU,7 SLL,8 SRL,9 SRA
- ImmSrc  out  3  000 I, 001 S, 010 B, 011 J, 100 U; combinational from op in every state
- state  out  4  current state encoding; illegal out 1: high while in HALT

## Operation
- States (encoding): FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, JAL 9, BRANCH 10, LUI 11, HALT 15.
- FETCH: AdrSrc 0, A=PC, B=4, ADD, ResultSrc 10; IRWrite and PCWrite = mem_ready; stays until mem_ready, then DECODE.
- DECODE: A=OldPC, B=imm, ADD (branch/jump target into ALUOut). Next on op: 0000011/0100011 → MEMADR; 0110011 → EXECR; 0010011 → EXECI; 1101111 → JAL; 1100011 → BRANCH; 0110111 → LUI; anything else, or branch funct3 010/011 (or 1xx when BRANCH_FULL=0) → HALT.
- MEMADR: A=rs1, B=imm, ADD; → MEMREAD if op[5]=0, else MEMWRITE.
- MEMREAD: AdrSrc 1; hold until mem_ready, then MEMWB. MEMWB: ResultSrc 01, RegWrite → FETCH.
- MEMWRITE: AdrSrc 1, MemWrite held high until mem_ready cycle inclusive, then FETCH.
- EXECR/EXECI: A=rs1, B=rs2/imm; ALU by funct3: 000 ADD (SUB only if EXECR and funct7_5), 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA by funct7_5, 110 OR, 111 AND; → ALUWB.
- ALUWB: ResultSrc 00, RegWrite → FETCH.
- JAL: A=OldPC, B=4, ADD, ResultSrc 00, PCWrite 1 (PC ← target) → ALUWB (rd ← PC+4).
- LUI: A=zero, B=imm, ADD → ALUWB.
- BRANCH: A=rs1, B=rs2, SUB, ResultSrc 00; PCWrite = taken; → FETCH. taken: 000 EQ, 001 !EQ, 100 LT, 101 !LT, 110 LTU, 111 !LTU.
- HALT: all write enables 0, illegal 1; exit only via reset.
- Unlisted outputs in a state: enables 0, selects 00, ALUctrl ADD.

## Timing
- Reset: state=FETCH asynchronously; while rst_n=0 all write enables (PCWrite, IRWrite, RegWrite, MemWrite) forced 0, illegal 0.
- First fetch on the first rising edge after rst_n deasserts.
- Zero-wait latencies: R/I-ALU 4, LUI 4, JAL 4, load 5, store 4, branch 3 cycles.
- Each wait cycle (mem_ready=0 in FETCH/MEMREAD/MEMWRITE) adds exactly one cycle; outputs stay stable while waiting.
- State transitions registered; outputs combinational from state plus op/funct3/flags/mem_ready (PCWrite in FETCH/BRANCH is Mealy).
- Reset mid-access: state returns to FETCH immediately, MemWrite drops same cycle.

## Test plan
- ADD x3,x1,x2 (op 0110011, f3 000, f7_5 0), mem_ready=1 → states 0,1,6,8; ALUctrl 0; RegWrite only in ALUWB; 4 cycles.
- LW with mem_ready low 2 cycles in MEMREAD → states 0,1,2,3,3,3,4; RegWrite with ResultSrc 01 in cycle 7.
- BLTU, LTU=1 → PCWrite=1 in BRANCH; LTU=0 → PCWrite=0; BRANCH_FULL=0 same instruction → HALT, illegal=1.
- SRAI (op 0010011, f3 101, f7_5 1) → ALUctrl 9; ADDI with IR[30]=1 → ALUctrl 0 (not SUB).
- JAL → JAL state PCWrite=1, then ALUWB RegWrite=1; ImmSrc 011 throughout.
- Assert rst_n=0 during MEMWRITE wait → MemWrite 0 same cycle, state 0; op 0000000 → HALT held until reset.
